// File: rtl/operand_reader.sv
// -----------------------------------------------------------------------------
// operand_reader
//
// Fetches 64-bit words from SRAM over an inclusive address range and hands
// each word to the adder datapath as two DATA_W-bit operands, lower half
// first, using a valid/ready handshake. One start pulse launches a transfer;
// a one-cycle done pulse reports completion.
//
// Ports
//   clk_i         clock, all logic on posedge
//   rst_i         synchronous active-high reset
//   start_i       start pulse, sampled only while idle
//   start_addr_i  first word address, latched on an accepted start
//   end_addr_i    last word address (inclusive), latched on an accepted start
//   busy_o        high whenever the reader is not idle
//   done_o        one-cycle pulse after the final upper half is accepted
//   mem_re_o      SRAM read enable
//   mem_addr_o    SRAM read address
//   mem_rdata_i   SRAM read data, valid one cycle after mem_re_o
//   op_valid_o    operand valid
//   op_ready_i    consumer ready
//   op_data_o     operand value
//   op_upper_o    0 = lower half of the word, 1 = upper half
//
// MEM_WORD_SIZE must equal 2*DATA_W.
// -----------------------------------------------------------------------------
module operand_reader #(
    parameter int DATA_W        = 32,
    parameter int MEM_WORD_SIZE = 64,
    parameter int ADDR_W        = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [ADDR_W-1:0]        start_addr_i,
    input  logic [ADDR_W-1:0]        end_addr_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     mem_re_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    input  logic [MEM_WORD_SIZE-1:0] mem_rdata_i,
    output logic                     op_valid_o,
    input  logic                     op_ready_i,
    output logic [DATA_W-1:0]        op_data_o,
    output logic                     op_upper_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_LOW  = 3'd3,
        S_HIGH = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0]        end_addr_q, end_addr_d;
    logic [MEM_WORD_SIZE-1:0] word_q, word_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cur_addr_q <= '0;
            end_addr_q <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            end_addr_q <= end_addr_d;
            word_q     <= word_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        end_addr_d = end_addr_q;
        word_d     = word_q;

        busy_o     = 1'b1;
        done_o     = 1'b0;
        mem_re_o   = 1'b0;
        mem_addr_o = '0;
        op_valid_o = 1'b0;
        op_data_o  = word_q[DATA_W-1:0];
        op_upper_o = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    cur_addr_d = start_addr_i;
                    end_addr_d = end_addr_i;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                mem_re_o   = 1'b1;
                mem_addr_o = cur_addr_q;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // SRAM returns data exactly one cycle after the read enable.
                word_d  = mem_rdata_i;
                state_d = S_LOW;
            end
            S_LOW: begin
                op_valid_o = 1'b1;
                if (op_ready_i) begin
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                op_valid_o = 1'b1;
                op_data_o  = word_q[MEM_WORD_SIZE-1:DATA_W];
                op_upper_o = 1'b1;
                if (op_ready_i) begin
                    if (cur_addr_q == end_addr_q) begin
                        state_d = S_DONE;
                    end else begin
                        // Natural ADDR_W overflow gives the wrap through the
                        // top of memory when end_addr < start_addr.
                        cur_addr_d = cur_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        state_d    = S_REQ;
                    end
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_operand_reader.sv
module tb_operand_reader;

    localparam int DATA_W = 32;
    localparam int MEM_W  = 64;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic              busy;
    logic              done;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [MEM_W-1:0]  mem_rdata;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_data;
    logic              op_upper;

    logic [MEM_W-1:0]  mem [0:(1<<ADDR_W)-1];

    int n_checks = 0;
    int n_fail   = 0;

    operand_reader #(
        .DATA_W(DATA_W), .MEM_WORD_SIZE(MEM_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .start_addr_i(start_addr),
        .end_addr_i  (end_addr),
        .busy_o      (busy),
        .done_o      (done),
        .mem_re_o    (mem_re),
        .mem_addr_o  (mem_addr),
        .mem_rdata_i (mem_rdata),
        .op_valid_o  (op_valid),
        .op_ready_i  (op_ready),
        .op_data_o   (op_data),
        .op_upper_o  (op_upper)
    );

    always #5 clk = ~clk;

    // SRAM model: one-cycle read latency, garbage when not reading.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        else        mem_rdata <= {$urandom, $urandom};
    end

    function automatic logic [MEM_W-1:0] word_of(input int a);
        logic [31:0] hi, lo;
        hi = 32'hC000_0000 + 32'(a);
        lo = 32'h3000_0000 + 32'(a * 3);
        return {hi, lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_done"},  64'(done), 64'd0);
        check({tag, "_re"},    64'(mem_re), 64'd0);
        check({tag, "_addr"},  64'(mem_addr), 64'd0);
        check({tag, "_valid"}, 64'(op_valid), 64'd0);
        check({tag, "_data"},  64'(op_data), 64'd0);
        check({tag, "_upper"}, 64'(op_upper), 64'd0);
    endtask

    initial begin
        logic [DATA_W-1:0] held_data;
        logic [MEM_W-1:0]  w;
        int addrs[$];
        int n_xfer, n_done, exp_addr;

        for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = word_of(a);
        mem[5] = 64'hDEADBEEF_12345678;

        // ---------------- reset with random inputs ----------------
        rst        = 1'b1;
        start      = 1'($urandom);
        start_addr = ADDR_W'($urandom);
        end_addr   = ADDR_W'($urandom);
        op_ready   = 1'($urandom);
        tick();
        start      = 1'b1;
        op_ready   = 1'($urandom);
        tick();
        check_idle("reset");
        rst      = 1'b0;
        start    = 1'b0;
        op_ready = 1'b1;
        tick();

        // ---------------- single word ----------------
        start_addr = 10'd5;
        end_addr   = 10'd5;
        start      = 1'b1;
        tick();                                   // cycle 1
        start = 1'b0;
        check("single_re_c1",   64'(mem_re), 64'd1);
        check("single_addr_c1", 64'(mem_addr), 64'd5);
        check("single_busy_c1", 64'(busy), 64'd1);
        tick();                                   // cycle 2
        check("single_valid_c2", 64'(op_valid), 64'd0);
        check("single_re_c2",    64'(mem_re), 64'd0);
        tick();                                   // cycle 3
        check("single_valid_c3", 64'(op_valid), 64'd1);
        check("single_data_c3",  64'(op_data), 64'h12345678);
        check("single_upper_c3", 64'(op_upper), 64'd0);
        tick();                                   // cycle 4
        check("single_data_c4",  64'(op_data), 64'hDEADBEEF);
        check("single_upper_c4", 64'(op_upper), 64'd1);
        check("single_done_c4",  64'(done), 64'd0);
        tick();                                   // cycle 5
        check("single_done_c5",  64'(done), 64'd1);
        check("single_valid_c5", 64'(op_valid), 64'd0);
        check("single_busy_c5",  64'(busy), 64'd1);
        tick();                                   // cycle 6
        check("single_busy_c6",  64'(busy), 64'd0);
        check("single_done_c6",  64'(done), 64'd0);

        // ---------------- backpressure (restart right after idle) ----------------
        start_addr = 10'd10;
        end_addr   = 10'd10;
        op_ready   = 1'b0;
        start      = 1'b1;
        tick();                                   // cycle 1
        start = 1'b0;
        tick();                                   // cycle 2
        tick();                                   // cycle 3
        w = word_of(10);
        for (int i = 0; i < 3; i++) begin         // cycles 3,4,5 stalled in LOW
            check("bp_low_valid", 64'(op_valid), 64'd1);
            check("bp_low_data",  64'(op_data), 64'(w[31:0]));
            check("bp_low_upper", 64'(op_upper), 64'd0);
            check("bp_low_re",    64'(mem_re), 64'd0);
            tick();
        end
        op_ready = 1'b1;                          // cycle 6: transfer
        check("bp_low_xfer_data", 64'(op_data), 64'(w[31:0]));
        tick();                                   // cycle 7
        op_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin         // cycles 7,8,9 stalled in HIGH
            check("bp_high_valid", 64'(op_valid), 64'd1);
            check("bp_high_data",  64'(op_data), 64'(w[63:32]));
            check("bp_high_upper", 64'(op_upper), 64'd1);
            check("bp_high_re",    64'(mem_re), 64'd0);
            check("bp_high_done",  64'(done), 64'd0);
            tick();
        end
        op_ready = 1'b1;                          // cycle 10: transfer
        tick();                                   // cycle 11 = 5 + 6
        check("bp_done_c11", 64'(done), 64'd1);
        tick();
        check("bp_busy_after", 64'(busy), 64'd0);

        // ---------------- wrap + ignored start ----------------
        start_addr = 10'd1022;
        end_addr   = 10'd1;
        start      = 1'b1;
        tick();
        start  = 1'b0;
        n_xfer = 0;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (mem_re) addrs.push_back(int'(mem_addr));
            if (op_valid && op_ready) begin
                exp_addr = (1022 + n_xfer / 2) % 1024;
                w = word_of(exp_addr);
                check("wrap_upper", 64'(op_upper), 64'(n_xfer % 2));
                check("wrap_data",  64'(op_data),
                      (n_xfer % 2) != 0 ? 64'(w[63:32]) : 64'(w[31:0]));
                n_xfer++;
            end
            if (done) n_done++;
            if (i == 6) begin
                start      = 1'b1;
                start_addr = 10'd100;
                end_addr   = 10'd100;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        check("wrap_nreads", 64'(addrs.size()), 64'd4);
        if (addrs.size() == 4) begin
            check("wrap_addr0", 64'(addrs[0]), 64'd1022);
            check("wrap_addr1", 64'(addrs[1]), 64'd1023);
            check("wrap_addr2", 64'(addrs[2]), 64'd0);
            check("wrap_addr3", 64'(addrs[3]), 64'd1);
        end
        check("wrap_nxfer", 64'(n_xfer), 64'd8);
        check("wrap_ndone", 64'(n_done), 64'd1);
        check("wrap_busy_end", 64'(busy), 64'd0);

        // ---------------- reset mid-transfer ----------------
        start_addr = 10'd200;
        end_addr   = 10'd200;
        start      = 1'b1;
        tick();                                   // cycle 1
        start = 1'b0;
        tick();                                   // cycle 2
        tick();                                   // cycle 3
        tick();                                   // cycle 4 (HIGH)
        check("rstmid_in_high", 64'(op_upper), 64'd1);
        rst = 1'b1;
        tick();
        check_idle("rstmid");
        rst = 1'b0;
        tick();
        check("rstmid_no_done", 64'(done), 64'd0);
        start_addr = 10'd300;
        end_addr   = 10'd300;
        start      = 1'b1;
        tick();                                   // cycle 1
        start = 1'b0;
        check("restart_addr", 64'(mem_addr), 64'd300);
        tick();
        tick();                                   // cycle 3
        w = word_of(300);
        check("restart_low",  64'(op_data), 64'(w[31:0]));
        tick();                                   // cycle 4
        check("restart_high", 64'(op_data), 64'(w[63:32]));
        tick();                                   // cycle 5
        check("restart_done", 64'(done), 64'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
